// File: rtl/exec_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : exec_iter_unit
//  Function : Execution unit with single-cycle ALU/shift ops and iterative
//             shift-add multiply and restoring divide (one bit per cycle).
//  Revision : 1.0  initial release
// ============================================================================
module exec_iter_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rstd,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       opr,
   input  logic [SHW-1:0]   shift,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_AND  = 5'd8;
   localparam logic [4:0] OP_OR   = 5'd9;
   localparam logic [4:0] OP_XOR  = 5'd10;
   localparam logic [4:0] OP_NAND = 5'd11;
   localparam logic [4:0] OP_SLL  = 5'd16;
   localparam logic [4:0] OP_SRL  = 5'd17;
   localparam logic [4:0] OP_SRA  = 5'd18;
   localparam logic [4:0] OP_MUL  = 5'd24;
   localparam logic [4:0] OP_DIVU = 5'd25;
   localparam logic [4:0] OP_REMU = 5'd26;

   localparam logic [1:0] K_MUL  = 2'd0;
   localparam logic [1:0] K_DIVU = 2'd1;
   localparam logic [1:0] K_REMU = 2'd2;

   localparam logic [SHW-1:0] C_CNT_LAST = SHW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [1:0]       r_kind;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;

   logic             w_accept;
   logic             w_iter_op;
   logic             w_last;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] w_sra;
   logic [WIDTH-1:0] w_mul_acc;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_div_rem;
   logic [WIDTH-1:0] w_div_quo;
   logic [WIDTH-1:0] w_iter_res;

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_ITER);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;

   assign w_accept  = in_valid & in_ready & ~flush;
   assign w_iter_op = (opr == OP_MUL) | (opr == OP_DIVU) | (opr == OP_REMU);
   assign w_last    = (r_cnt == C_CNT_LAST);
   assign w_sra     = $unsigned($signed(operand1) >>> shift);

   always_comb begin
      w_alu = '1;
      case (opr)
         OP_ADD:  w_alu = operand1 + operand2;
         OP_SUB:  w_alu = operand1 - operand2;
         OP_AND:  w_alu = operand1 & operand2;
         OP_OR:   w_alu = operand1 | operand2;
         OP_XOR:  w_alu = operand1 ^ operand2;
         OP_NAND: w_alu = ~(operand1 & operand2);
         OP_SLL:  w_alu = operand1 << shift;
         OP_SRL:  w_alu = operand1 >> shift;
         OP_SRA:  w_alu = w_sra;
         default: w_alu = '1;
      endcase
   end

   // Multiply: r_a is the shifting multiplicand, r_b the shifting multiplier.
   // Divide: r_a shifts dividend bits out and quotient bits in, r_acc is the
   // partial remainder; a zero divisor naturally yields all-ones / dividend.
   assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
   assign w_rem_sh  = {r_acc, r_a[WIDTH-1]};
   assign w_diff    = w_rem_sh - {1'b0, r_b};
   assign w_div_rem = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
   assign w_div_quo = {r_a[WIDTH-2:0], ~w_diff[WIDTH]};

   always_comb begin
      w_iter_res = w_div_rem;
      case (r_kind)
         K_MUL:   w_iter_res = w_mul_acc;
         K_DIVU:  w_iter_res = w_div_quo;
         default: w_iter_res = w_div_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state  <= S_IDLE;
         r_kind   <= K_MUL;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_iter_op) begin
                     r_state <= S_ITER;
                     r_cnt   <= '0;
                     r_a     <= operand1;
                     r_b     <= operand2;
                     r_acc   <= '0;
                     r_kind  <= (opr == OP_MUL)  ? K_MUL :
                                (opr == OP_DIVU) ? K_DIVU : K_REMU;
                  end else begin
                     r_state  <= S_DONE;
                     r_result <= w_alu;
                  end
               end
            end
            S_ITER: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_kind == K_MUL) begin
                  r_acc <= w_mul_acc;
                  r_a   <= r_a << 1;
                  r_b   <= r_b >> 1;
               end else begin
                  r_acc <= w_div_rem;
                  r_a   <= w_div_quo;
               end
               if (w_last) begin
                  r_state  <= S_DONE;
                  r_result <= w_iter_res;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exec_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_iter_unit
//  Function : Directed self-checking bench for exec_iter_unit (WIDTH=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_exec_iter_unit;

   logic        clk;
   logic        rstd;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  opr;
   logic [4:0]  shift;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int n_checks;
   int n_pass;

   exec_iter_unit #(.WIDTH(32), .SHW(5)) u_dut (
      .clk       (clk),
      .rstd      (rstd),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opr       (opr),
      .shift     (shift),
      .operand1  (operand1),
      .operand2  (operand2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Present a request for one edge, then scramble operands so later
   // changes on the inputs cannot leak into the operation in flight.
   task automatic send(input logic [4:0] op, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      opr = op; shift = sh; operand1 = a; operand2 = b; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opr      = 5'($urandom);
      shift    = 5'($urandom);
      operand1 = $urandom;
      operand2 = $urandom;
   endtask

   task automatic collect(input string tag, input int lat, input logic [31:0] exp,
                          input int stall);
      int          cyc;
      logic        busy_ok;
      logic [31:0] held;
      cyc     = 0;
      busy_ok = 1'b1;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (out_valid) break;
         if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
      end
      check({tag, "_lat"}, 32'(cyc), 32'(lat));
      check({tag, "_res"}, result, exp);
      if (lat > 1) check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      if (stall > 0) begin
         held = result;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {result, 1'b0}, {held, 1'b0});
            check({tag, "_hold_flags"}, {30'd0, out_valid, in_ready}, 32'b10);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      check({tag, "_ret_idle"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int stall);
      out_ready = (stall == 0);
      send(op, sh, a, b);
      collect(tag, lat, exp, stall);
      out_ready = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rstd     = 1'b0;
      in_valid = 1'b0;
      opr      = '0;
      shift    = '0;
      operand1 = '0;
      operand2 = '0;
      flush    = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
      check("rst_result", result, 32'h0);
      rstd = 1'b1;

      // single-cycle operations
      run_op("add",   5'd0,  5'd0,  32'h0fffffff, 32'h00000001, 32'h10000000, 1, 0);
      run_op("sub",   5'd1,  5'd0,  32'h00000005, 32'h00000007, 32'hfffffffe, 1, 0);
      run_op("and",   5'd8,  5'd0,  32'hf0f0ff00, 32'h0ff0f0f0, 32'h00f0f000, 1, 0);
      run_op("or",    5'd9,  5'd0,  32'hf0f0ff00, 32'h0ff0f0f0, 32'hfff0fff0, 1, 0);
      run_op("xor",   5'd10, 5'd0,  32'hf0f0ff00, 32'h0ff0f0f0, 32'hff000ff0, 1, 0);
      run_op("nand",  5'd11, 5'd0,  32'hf0f0ff00, 32'h0ff0f0f0, 32'hff0f0fff, 1, 0);
      run_op("undef", 5'd2,  5'd0,  32'h12345678, 32'h9abcdef0, 32'hffffffff, 1, 0);
      run_op("sra",   5'd18, 5'd1,  32'h92345678, 32'h0,        32'hc91a2b3c, 1, 0);
      run_op("srl",   5'd17, 5'd1,  32'h92345678, 32'h0,        32'h491a2b3c, 1, 0);
      run_op("sll",   5'd16, 5'd1,  32'h12345678, 32'h0,        32'h2468acf0, 1, 0);
      run_op("sll31", 5'd16, 5'd31, 32'h00000001, 32'h0,        32'h80000000, 1, 0);
      run_op("sra31", 5'd18, 5'd31, 32'h80000000, 32'h0,        32'hffffffff, 1, 0);

      // iterative operations
      run_op("mul",    5'd24, 5'd0, 32'h00012345, 32'h00000100, 32'h01234500, 33, 0);
      run_op("mulmax", 5'd24, 5'd0, 32'hffffffff, 32'hffffffff, 32'h00000001, 33, 0);
      run_op("divu",   5'd25, 5'd0, 32'd100,      32'd7,        32'd14,       33, 0);
      run_op("remu",   5'd26, 5'd0, 32'd100,      32'd7,        32'd2,        33, 0);
      run_op("divu0",  5'd25, 5'd0, 32'd5,        32'd0,        32'hffffffff, 33, 0);
      run_op("remu0",  5'd26, 5'd0, 32'd5,        32'd0,        32'd5,        33, 0);

      // output backpressure
      run_op("stall",  5'd0,  5'd0, 32'd1,        32'd2,        32'd3,        1,  5);

      // flush beats accept in IDLE
      @(negedge clk);
      opr = 5'd0; operand1 = 32'd9; operand2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_vs_accept", {29'd0, in_ready, out_valid, busy}, 32'b100);
      check("flush_vs_accept_res", result, 32'd3);

      // flush in the middle of a multiply
      send(5'd24, 5'd0, 32'h00012345, 32'h00000100);
      repeat (10) @(negedge clk);
      check("flush_pre_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", {29'd0, in_ready, out_valid, busy}, 32'b100);
      check("flush_res_kept", result, 32'd3);
      begin
         logic seen;
         seen = 1'b0;
         repeat (35) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         check("flush_no_valid", {31'd0, seen}, 32'd0);
      end
      run_op("post_flush_add", 5'd0, 5'd0, 32'd40, 32'd2, 32'd42, 1, 0);

      // asynchronous reset in the middle of a multiply
      send(5'd24, 5'd0, 32'h00012345, 32'h00000100);
      repeat (10) @(negedge clk);
      #2;
      rstd = 1'b0;
      #1;
      check("arst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
      check("arst_result", result, 32'h0);
      @(negedge clk);
      rstd = 1'b1;
      run_op("post_rst_add", 5'd0, 5'd0, 32'h0fffffff, 32'h00000001, 32'h10000000, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exec_iter_unit.md
EXEC_ITER_UNIT -- requirements
Module: exec_iter_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits (even, >=8).
REQ-002 SHALL provide parameter SHW, default 5, shift-amount width; WIDTH = 2**SHW.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port rstd  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port in_valid  input  1  operation request present.
REQ-006 SHALL provide port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL provide port opr  input  5  operation code, sampled on accept.
REQ-008 SHALL provide port shift  input  SHW  shift amount, sampled on accept.
REQ-009 SHALL provide port operand1  input  WIDTH  first operand, sampled on accept.
REQ-010 SHALL provide port operand2  input  WIDTH  second operand, sampled on accept.
REQ-011 SHALL provide port flush  input  1  synchronous abort of the current operation.
REQ-012 SHALL provide port out_valid  output  1  result valid.
REQ-013 SHALL provide port out_ready  input  1  consumer takes the result.
REQ-014 SHALL provide port result  output  WIDTH  operation result, registered.
REQ-015 SHALL provide port busy  output  1  high in ITER state.

Function
REQ-016 SHALL implement FSM states IDLE, ITER, DONE; in_ready = (state==IDLE); busy = (state==ITER); out_valid = (state==DONE).
REQ-017 Accept SHALL occur on a rising edge with in_valid & in_ready & !flush; opr, shift, operand1, operand2 are captured.
REQ-018 Single-cycle ops: 0 add, 1 sub, 8 and, 9 or, 10 xor, 11 nand, 16 sll(operand1,shift), 17 srl, 18 sra (sign-extending); all modulo 2**WIDTH; on accept SHALL go IDLE->DONE with result loaded, so out_valid rises 1 cycle after accept.
REQ-019 Any other opr not listed in REQ-018/REQ-020 SHALL take the single-cycle path with result = all ones.
REQ-020 Iterative ops: 24 mul (low WIDTH bits of unsigned product, shift-add, one bit per cycle), 25 divu (unsigned quotient), 26 remu (unsigned remainder, restoring division, one bit per cycle); on accept SHALL go IDLE->ITER.
REQ-021 An iteration counter SHALL count WIDTH cycles in ITER; after the WIDTH-th ITER cycle the FSM SHALL enter DONE, so out_valid rises exactly WIDTH+1 cycles after accept.
REQ-022 Division by zero SHALL still take WIDTH+1 cycles and yield divu = all ones, remu = operand1.
REQ-023 In DONE, result and out_valid SHALL hold stable until out_valid & out_ready; that edge SHALL return the FSM to IDLE (in_ready high the next cycle; no same-cycle accept).
REQ-024 flush high on a rising edge SHALL force IDLE from any state, clear out_valid and counter, leave result unchanged; flush has priority over accept and over output handshake.
REQ-025 result SHALL change only on entry into DONE or reset.
REQ-026 Operand values during ITER/DONE SHALL not affect the operation in progress.

Reset
REQ-027 rstd low SHALL immediately force state IDLE, counter 0, result 0, out_valid 0, busy 0, in_ready 1 after release; any operation in progress is discarded.
REQ-028 First accept SHALL be possible on the first rising edge with rstd high.

Verification (WIDTH=32)
REQ-029 add 0x0fffffff+0x00000001 -> result 0x10000000, out_valid 1 cycle after accept; opr 2 -> 0xffffffff.
REQ-030 sra 0x92345678 shift 1 -> 0xc91a2b3c; srl same -> 0x491a2b3c; sll 0x12345678 shift 1 -> 0x2468acf0.
REQ-031 mul 0x00012345*0x00000100 -> 0x01234500; in_ready 0 and busy 1 for 32 cycles, out_valid on cycle 33; mul 0xffffffff*0xffffffff -> 0x00000001.
REQ-032 divu 100/7 -> 14, remu 100/7 -> 2; divu 5/0 -> 0xffffffff, remu 5/0 -> 5, each 33 cycles.
REQ-033 out_ready low 5 cycles in DONE -> result and out_valid stable, in_ready 0; handshake -> IDLE next cycle.
REQ-034 rstd low at ITER cycle 10 of mul -> all outputs at reset values; flush at ITER cycle 10 -> IDLE next cycle, no out_valid, next add accepted normally.
